// File: rtl/online_digit_sequencer.sv
// online_digit_sequencer: master cycle count, digit FIFO and flush
// sequencing ahead of computation_control in the online multiplier.
module online_digit_sequencer #(
  parameter int N_DIGITS   = 32,
  parameter int DELTA      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       enable_for_input,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_x,
  input  logic [1:0] in_y,
  output logic [8:0] cnt_master,
  output logic [1:0] x_digit,
  output logic [1:0] y_digit,
  output logic       digit_valid,
  output logic [6:0] digit_idx,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    FIN
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [6:0] N_C = N_DIGITS[6:0];
  localparam logic [2:0] DELTA_C = DELTA[2:0];
  localparam logic [8:0] CNT_MAX = 9'd511;

  state_t state, state_n;

  // entry layout: {bad, x, y}
  logic [4:0] mem [FIFO_DEPTH];
  logic [4:0] head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_n;
  logic [6:0] accepted, accepted_n;
  logic [6:0] consumed;
  logic [2:0] flushed;
  logic in_ready_n;
  logic push, pop, empty, bad;
  logic [1:0] sx, sy;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign push  = in_valid & in_ready;
  assign pop   = enable_for_input & (state == RUN) & ~empty;
  assign bad   = (in_x == 2'b10) | (in_y == 2'b10);
  assign sx    = (in_x == 2'b10) ? 2'b00 : in_x;
  assign sy    = (in_y == 2'b10) ? 2'b00 : in_y;

  // next state, FIFO occupancy, accepted count and the ready they imply
  always_comb begin
    state_n    = state;
    count_n    = count;
    accepted_n = accepted;
    if (push & ~pop) begin
      count_n = count + (AW+1)'(1);
    end else if (~push & pop) begin
      count_n = count - (AW+1)'(1);
    end
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = RUN;
          accepted_n = 7'(count) + 7'(push);
        end else begin
          accepted_n = accepted + 7'(push);
        end
      end
      RUN: begin
        accepted_n = accepted + 7'(push);
        if (enable_for_input && consumed == N_C - 7'd1) begin
          state_n = (DELTA == 0) ? FIN : FLUSH;
        end
      end
      FLUSH: begin
        if (enable_for_input && flushed == DELTA_C - 3'd1) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n    = IDLE;
        accepted_n = '0;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n = (count_n != DEPTH_C) &
                 ((state_n == IDLE) | (state_n == RUN)) &
                 (accepted_n < N_C);
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bad, sx, sy};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // sequencing FSM with registered digit, count and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      accepted    <= '0;
      consumed    <= '0;
      flushed     <= '0;
      in_ready    <= 1'b0;
      cnt_master  <= '0;
      x_digit     <= '0;
      y_digit     <= '0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_n;
      accepted    <= accepted_n;
      in_ready    <= in_ready_n;
      digit_valid <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt_master <= '0;
          if (start) begin
            busy     <= 1'b1;
            underrun <= 1'b0;
            illegal  <= 1'b0;
            consumed <= '0;
            flushed  <= '0;
          end
        end
        RUN: begin
          if (cnt_master != CNT_MAX) begin
            cnt_master <= cnt_master + 9'd1;
          end else begin
            underrun <= 1'b1;
          end
          if (enable_for_input) begin
            digit_valid <= 1'b1;
            digit_idx   <= consumed;
            consumed    <= consumed + 7'd1;
            if (!empty) begin
              x_digit <= head[3:2];
              y_digit <= head[1:0];
              if (head[4]) illegal <= 1'b1;
            end else begin
              x_digit  <= 2'b00;
              y_digit  <= 2'b00;
              underrun <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (cnt_master != CNT_MAX) begin
            cnt_master <= cnt_master + 9'd1;
          end
          if (enable_for_input) begin
            digit_valid <= 1'b1;
            digit_idx   <= N_C + 7'(flushed);
            flushed     <= flushed + 3'd1;
            x_digit     <= 2'b00;
            y_digit     <= 2'b00;
          end
        end
        FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          cnt_master <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_online_digit_sequencer.sv
// tb_online_digit_sequencer: random and directed operations checked
// against a queue-based reference model through a digit scoreboard.
module tb_online_digit_sequencer;

  localparam int N = 32;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       enable_for_input = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_x = 2'b00;
  logic [1:0] in_y = 2'b00;
  logic       in_ready;
  logic [8:0] cnt_master;
  logic [1:0] x_digit, y_digit;
  logic       digit_valid;
  logic [6:0] digit_idx;
  logic       busy, done, underrun, illegal;

  online_digit_sequencer #(.N_DIGITS(N), .DELTA(D), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .enable_for_input(enable_for_input),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .cnt_master(cnt_master),
    .x_digit(x_digit), .y_digit(y_digit),
    .digit_valid(digit_valid), .digit_idx(digit_idx),
    .busy(busy), .done(done), .underrun(underrun), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic [6:0] idx;
  } dig_t;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    bit         bad;
  } pair_t;

  dig_t  exp_q[$];
  pair_t buf_q[$];

  // reference model state: phase 0 idle, 1 run, 2 flush, 3 fin
  int ph, m_cnt, m_acc, m_cons, m_fl;
  bit m_busy, m_done, m_und, m_ill, m_rdy;
  logic [1:0] m_x, m_y;

  int errs = 0;
  int checks = 0;
  int pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_cnt = 0; m_acc = 0; m_cons = 0; m_fl = 0;
    m_busy = 0; m_done = 0; m_und = 0; m_ill = 0; m_rdy = 0;
    m_x = 2'b00; m_y = 2'b00;
    buf_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    bit push, acc_set;
    pair_t p;
    dig_t d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    push = in_valid && m_rdy;
    acc_set = 0;
    m_done = 0;
    case (ph)
      0: if (start) begin
        ph = 1; m_busy = 1; m_cnt = 0; m_und = 0; m_ill = 0;
        m_cons = 0; m_fl = 0;
        m_acc = buf_q.size() + int'(push);
        acc_set = 1;
      end
      1: begin
        if (m_cnt == 511) m_und = 1; else m_cnt++;
        if (enable_for_input) begin
          if (buf_q.size() > 0) begin
            p = buf_q.pop_front();
            if (p.bad) m_ill = 1;
            m_x = p.x; m_y = p.y;
          end else begin
            m_x = 2'b00; m_y = 2'b00; m_und = 1;
          end
          d.x = m_x; d.y = m_y; d.idx = 7'(m_cons);
          exp_q.push_back(d);
          m_cons++;
          if (m_cons == N) ph = (D == 0) ? 3 : 2;
        end
      end
      2: begin
        if (m_cnt != 511) m_cnt++;
        if (enable_for_input) begin
          m_x = 2'b00; m_y = 2'b00;
          d.x = 2'b00; d.y = 2'b00; d.idx = 7'(N + m_fl);
          exp_q.push_back(d);
          m_fl++;
          if (m_fl == D) ph = 3;
        end
      end
      default: begin
        m_done = 1; m_busy = 0; m_cnt = 0; m_acc = 0; ph = 0;
        acc_set = 1;
      end
    endcase
    if (push) begin
      p.bad = (in_x == 2'b10) || (in_y == 2'b10);
      p.x = (in_x == 2'b10) ? 2'b00 : in_x;
      p.y = (in_y == 2'b10) ? 2'b00 : in_y;
      buf_q.push_back(p);
      if (!acc_set) m_acc++;
    end
    m_rdy = (buf_q.size() < 4) && (ph == 0 || ph == 1) && (m_acc < N);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: per-cycle status plus digit scoreboard
  initial forever begin
    dig_t e;
    @(negedge clk);
    check("in_ready", int'(in_ready), int'(m_rdy));
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("underrun", int'(underrun), int'(m_und));
    check("illegal", int'(illegal), int'(m_ill));
    check("cnt_master", int'(cnt_master), m_cnt);
    check("x_hold", int'(x_digit), int'(m_x));
    check("y_hold", int'(y_digit), int'(m_y));
    if (digit_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_digit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("digit_x", int'(x_digit), int'(e.x));
        check("digit_y", int'(y_digit), int'(e.y));
        check("digit_idx", int'(digit_idx), int'(e.idx));
      end
    end else begin
      check("missing_digit", exp_q.size(), 0);
    end
  end

  function automatic logic [1:0] rand_dig();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 2'b10;
    if (r < 4) return 2'b00;
    if (r < 7) return 2'b01;
    return 2'b11;
  endfunction

  task automatic drive(input int pv, input int pe, input int period,
                       input int c);
    in_valid = ($urandom_range(0, 99) < pv);
    in_x = rand_dig();
    in_y = rand_dig();
    if (period > 0) enable_for_input = (c % period == 0);
    else enable_for_input = ($urandom_range(0, 99) < pe);
  endtask

  task automatic run_op(input int pv, input int pe, input int period);
    bit fin;
    fin = 0;
    @(negedge clk);
    start = 1'b1;
    pulses = 0;
    drive(pv, pe, period, 0);
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        fin = 1;
        break;
      end
      drive(pv, pe, period, c);
    end
    in_valid = 1'b0;
    enable_for_input = 1'b0;
    if (!fin) check("op_timeout", 0, 1);
    else check("pulse_count", pulses, N + D);
  endtask

  task automatic prefill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = rand_dig();
      in_y = rand_dig();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    bit hit;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cnt", int'(cnt_master), 0);
    check("rst_valid", int'(digit_valid), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    prefill(6);
    check("prefill_full", int'(in_ready), 0);
    run_op(70, 0, 4);

    run_op(100, 100, 0);
    check("full_underrun", int'(underrun), 0);
    check("full_cnt_zero", int'(cnt_master), 0);

    run_op(0, 100, 0);
    check("underrun_sticky", int'(underrun), 1);

    @(negedge clk);
    in_valid = 1'b1; in_x = 2'b10; in_y = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    run_op(60, 60, 0);
    check("illegal_sticky", int'(illegal), 1);

    prefill(3);
    run_op(100, 100, 0);

    for (int k = 0; k < 5; k++) begin
      if (k[0]) prefill($urandom_range(0, 5));
      run_op($urandom_range(20, 100), $urandom_range(20, 100), 0);
    end

    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    enable_for_input = 1'b1;
    @(negedge clk);
    start = 1'b0;
    enable_for_input = 1'b0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (cnt_master == 9'd57) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("reach_57", int'(hit), 1);
    #2 rst_n = 1'b0;
    model_reset();
    in_valid = 1'b0;
    #1;
    check("arst_cnt", int'(cnt_master), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(digit_valid), 0);
    check("arst_idx", int'(digit_idx), 0);
    check("arst_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(80, 80, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
